mole_round_sequencer: RTL and testbench



---
 rtl/mole_round_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_mole_round_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_round_sequencer.sv
// Whack-a-mole round controller: sequences timed moles from the LFSR, judges
// edge-detected button hits against a per-mole window that shrinks per level.
module mole_round_sequencer #(
  parameter int unsigned GAP_CYCLES     = 1000,
  parameter int unsigned WINDOW_INIT    = 500000,
  parameter int unsigned WINDOW_STEP    = 50000,
  parameter int unsigned WINDOW_MIN     = 100000,
  parameter int unsigned MOLES_PER_GAME = 32,
  parameter int unsigned HITS_PER_LEVEL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic [2:0] rand_seg,
  input  logic [7:0] btn_sync,
  output logic       mole_valid,
  output logic [2:0] mole_seg,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [7:0] hits,
  output logic [7:0] misses,
  output logic [2:0] level,
  output logic       game_over
);

  localparam int unsigned      GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [19:0]      WIN_INIT  = 20'(WINDOW_INIT);
  localparam logic [19:0]      WIN_STEP  = 20'(WINDOW_STEP);
  localparam logic [19:0]      WIN_MIN   = 20'(WINDOW_MIN);
  localparam logic [7:0]       MOLE_LAST = 8'(MOLES_PER_GAME);

  typedef enum logic [1:0] {IDLE, GAP, SHOW, DONE} state_t;

  state_t           state_q;
  logic             start_prev_q;
  logic [7:0]       btn_prev_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [19:0]      win_cnt_q;
  logic [19:0]      window_q;
  logic [7:0]       mole_cnt_q;
  logic [8:0]       hit_tot_q;
  logic             mole_valid_q;
  logic [2:0]       mole_seg_q;
  logic             hit_pulse_q;
  logic             miss_pulse_q;
  logic [7:0]       hits_q;
  logic [7:0]       misses_q;
  logic [2:0]       level_q;
  logic             game_over_q;

  logic             start_rise_d;
  logic [7:0]       btn_rise_d;
  logic [7:0]       seg_mask_d;
  logic             hit_d;
  logic             wrong_d;
  logic             timeout_d;
  logic [8:0]       hit_tot_d;
  logic             level_up_d;
  logic [7:0]       mole_cnt_d;
  logic             last_mole_d;
  logic [2:0]       seg_latch_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  // Underflow is caught before the floor clamp so a small window never wraps.
  function automatic logic [19:0] shrink_window(input logic [19:0] w);
    logic [19:0] diff;
    diff = w - WIN_STEP;
    if ((w < WIN_STEP) || (diff < WIN_MIN)) return WIN_MIN;
    return diff;
  endfunction

  always_comb begin
    start_rise_d = start_btn & ~start_prev_q;
    btn_rise_d   = btn_sync & ~btn_prev_q;
    seg_mask_d   = 8'd1 << mole_seg_q;
    hit_d        = btn_rise_d[mole_seg_q];
    wrong_d      = |(btn_rise_d & ~seg_mask_d);
    timeout_d    = (win_cnt_q == 20'd1);
    hit_tot_d    = hit_tot_q + 9'd1;
    level_up_d   = ((32'(hit_tot_d) % HITS_PER_LEVEL) == 32'd0);
    mole_cnt_d   = mole_cnt_q + 8'd1;
    last_mole_d  = (mole_cnt_d == MOLE_LAST);
    seg_latch_d  = (rand_seg == 3'd7) ? 3'd0 : rand_seg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      btn_prev_q   <= 8'd0;
      gap_cnt_q    <= '0;
      win_cnt_q    <= 20'd0;
      window_q     <= WIN_INIT;
      mole_cnt_q   <= 8'd0;
      hit_tot_q    <= 9'd0;
      mole_valid_q <= 1'b0;
      mole_seg_q   <= 3'd0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      hits_q       <= 8'd0;
      misses_q     <= 8'd0;
      level_q      <= 3'd0;
      game_over_q  <= 1'b0;
    end else begin
      start_prev_q <= start_btn;
      btn_prev_q   <= btn_sync;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      if (start_rise_d) begin
        // A new game silently abandons whatever mole was on screen.
        hits_q       <= 8'd0;
        misses_q     <= 8'd0;
        level_q      <= 3'd0;
        hit_tot_q    <= 9'd0;
        mole_cnt_q   <= 8'd0;
        window_q     <= WIN_INIT;
        mole_valid_q <= 1'b0;
        gap_cnt_q    <= '0;
        game_over_q  <= 1'b0;
        state_q      <= GAP;
      end else begin
        case (state_q)
          IDLE: ;
          GAP: begin
            mole_valid_q <= 1'b0;
            gap_cnt_q    <= gap_cnt_q + GAP_W'(1);
            if (gap_cnt_q == GAP_LAST) begin
              gap_cnt_q    <= '0;
              mole_seg_q   <= seg_latch_d;
              win_cnt_q    <= window_q;
              mole_valid_q <= 1'b1;
              state_q      <= SHOW;
            end
          end
          SHOW: begin
            if (hit_d || wrong_d || timeout_d) begin
              if (hit_d) begin
                hit_pulse_q <= 1'b1;
                hits_q      <= sat_inc8(hits_q);
                hit_tot_q   <= hit_tot_d;
                if (level_up_d) begin
                  level_q  <= sat_inc3(level_q);
                  window_q <= shrink_window(window_q);
                end
              end else begin
                miss_pulse_q <= 1'b1;
                misses_q     <= sat_inc8(misses_q);
              end
              mole_valid_q <= 1'b0;
              mole_cnt_q   <= mole_cnt_d;
              if (last_mole_d) begin
                game_over_q <= 1'b1;
                state_q     <= DONE;
              end else begin
                gap_cnt_q <= '0;
                state_q   <= GAP;
              end
            end else begin
              win_cnt_q <= win_cnt_q - 20'd1;
            end
          end
          DONE: begin
            game_over_q  <= 1'b1;
            mole_valid_q <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign mole_valid = mole_valid_q;
  assign mole_seg   = mole_seg_q;
  assign hit_pulse  = hit_pulse_q;
  assign miss_pulse = miss_pulse_q;
  assign hits       = hits_q;
  assign misses     = misses_q;
  assign level      = level_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_mole_round_sequencer.sv
// Bench for mole_round_sequencer: directed games plus randomized games, each
// checked against a per-mole score/window model.
module tb_mole_round_sequencer;

  localparam int GAP   = 4;
  localparam int WINIT = 20;
  localparam int STEP  = 5;
  localparam int WMIN  = 8;
  localparam int MOLES = 4;
  localparam int HPL   = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_btn = 1'b0;
  logic [2:0] rand_seg  = 3'd0;
  logic [7:0] btn_sync  = 8'd0;
  logic       mole_valid;
  logic [2:0] mole_seg;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [7:0] hits;
  logic [7:0] misses;
  logic [2:0] level;
  logic       game_over;

  mole_round_sequencer #(
    .GAP_CYCLES(GAP), .WINDOW_INIT(WINIT), .WINDOW_STEP(STEP),
    .WINDOW_MIN(WMIN), .MOLES_PER_GAME(MOLES), .HITS_PER_LEVEL(HPL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .rand_seg(rand_seg),
    .btn_sync(btn_sync), .mole_valid(mole_valid), .mole_seg(mole_seg),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .hits(hits),
    .misses(misses), .level(level), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model of the game score, kept per mole.
  int m_hits, m_misses, m_level, m_window, m_moles, m_total;
  logic [2:0] cur_seg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_new();
    m_hits = 0; m_misses = 0; m_level = 0; m_moles = 0; m_total = 0;
    m_window = WINIT;
  endtask

  task automatic model_hit();
    m_total++;
    if (m_hits < 255) m_hits++;
    if (m_total % HPL == 0) begin
      if (m_level < 7) m_level++;
      m_window = (m_window - STEP < WMIN) ? WMIN : m_window - STEP;
    end
    m_moles++;
  endtask

  task automatic model_miss();
    if (m_misses < 255) m_misses++;
    m_moles++;
  endtask

  task automatic check_scores(input string tag);
    check({tag, "_hits"}, hits, m_hits);
    check({tag, "_misses"}, misses, m_misses);
    check({tag, "_level"}, level, m_level);
    check({tag, "_game_over"}, game_over, (m_moles == MOLES) ? 1 : 0);
    check({tag, "_valid_low"}, mole_valid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, mole_valid, 0);
    check({tag, "_seg"}, mole_seg, 0);
    check({tag, "_pulses"}, {hit_pulse, miss_pulse}, 0);
    check({tag, "_hits"}, hits, 0);
    check({tag, "_misses"}, misses, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_game_over"}, game_over, 0);
  endtask

  task automatic start_game();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    model_new();
    check("start_hits", hits, 0);
    check("start_misses", misses, 0);
    check("start_level", level, 0);
    check("start_game_over", game_over, 0);
    check("start_valid", mole_valid, 0);
  endtask

  // Called on the cycle GAP was entered; the mole must appear GAP cycles later.
  task automatic wait_mole(input logic [2:0] rs);
    int k = 0;
    int pulses = 0;
    rand_seg = rs;
    cur_seg  = (rs == 3'd7) ? 3'd0 : rs;
    while (mole_valid !== 1'b1 && k < 200) begin
      step();
      k++;
      if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0) pulses++;
    end
    check("mole_latency", k, GAP);
    check("gap_no_pulse", pulses, 0);
    check("mole_seg", mole_seg, cur_seg);
    check("mole_seg_range", (mole_seg <= 3'd6) ? 1 : 0, 1);
  endtask

  task automatic show_steps(input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      rand_seg = 3'($urandom);
      step();
      if (mole_valid !== 1'b1 || mole_seg !== cur_seg ||
          hit_pulse !== 1'b0 || miss_pulse !== 1'b0) bad++;
    end
    check("show_hold", bad, 0);
  endtask

  task automatic do_hit(input int off);
    show_steps(off);
    btn_sync = 8'd1 << cur_seg;
    step();
    btn_sync = 8'd0;
    check("hit_pulse", hit_pulse, 1);
    check("hit_no_miss", miss_pulse, 0);
    model_hit();
    check_scores("hit");
  endtask

  task automatic do_wrong(input int off);
    int b;
    show_steps(off);
    do b = $urandom_range(0, 7); while (b == int'(cur_seg));
    btn_sync = 8'd1 << b;
    step();
    btn_sync = 8'd0;
    check("wrong_miss", miss_pulse, 1);
    check("wrong_no_hit", hit_pulse, 0);
    model_miss();
    check_scores("wrong");
  endtask

  task automatic do_timeout();
    int k = 0;
    int bad = 0;
    do begin
      rand_seg = 3'($urandom);
      step();
      k++;
      if (mole_valid === 1'b1 && (mole_seg !== cur_seg ||
          hit_pulse !== 1'b0 || miss_pulse !== 1'b0)) bad++;
    end while (mole_valid === 1'b1 && k < 2000);
    check("timeout_len", k, m_window);
    check("timeout_hold", bad, 0);
    check("timeout_miss", miss_pulse, 1);
    check("timeout_no_hit", hit_pulse, 0);
    model_miss();
    check_scores("timeout");
  endtask

  task automatic done_idle();
    int bad = 0;
    for (int i = 0; i < 6; i++) begin
      btn_sync = 8'($urandom);
      step();
      if (game_over !== 1'b1 || mole_valid !== 1'b0 || hit_pulse !== 1'b0 ||
          miss_pulse !== 1'b0 || hits !== 8'(m_hits) || misses !== 8'(m_misses)) bad++;
    end
    btn_sync = 8'd0;
    check("done_hold", bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int act;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    step(); step(); step();
    check_all_zero("reset");
    rst_n = 1'b1;

    bad = 0;
    for (int i = 0; i < 50; i++) begin
      rand_seg = 3'($urandom);
      btn_sync = 8'($urandom);
      step();
      if (mole_valid !== 1'b0 || hits !== 8'd0 || game_over !== 1'b0 ||
          hit_pulse !== 1'b0 || miss_pulse !== 1'b0) bad++;
    end
    btn_sync = 8'd0;
    check("idle_hold", bad, 0);
    check_all_zero("idle");

    // Game A: every mole hit; last one on the window's final cycle.
    start_game();
    for (int m = 0; m < MOLES; m++) begin
      wait_mole(3'($urandom_range(0, 6)));
      do_hit((m == MOLES - 1) ? m_window - 1 : $urandom_range(0, m_window - 1));
    end
    check("gameA_hits", hits, 4);
    check("gameA_level", level, 2);
    check("gameA_misses", misses, 0);
    check("gameA_game_over", game_over, 1);
    done_idle();

    // Game B: no presses, every mole times out after the initial window.
    start_game();
    for (int m = 0; m < MOLES; m++) begin
      wait_mole(3'($urandom));
      do_timeout();
    end
    check("gameB_misses", misses, 4);
    check("gameB_hits", hits, 0);
    check("gameB_game_over", game_over, 1);
    done_idle();

    // Game C: wrong button, held button, segment 7 with hit on expiry cycle,
    // then a timeout that must use the shrunken window.
    start_game();
    wait_mole(3'd3);
    do_wrong($urandom_range(0, m_window - 1));
    check("gameC_misses1", misses, 1);
    btn_sync = 8'b0000_0100;
    wait_mole(3'd2);
    show_steps(3);
    btn_sync = 8'd0;
    show_steps(1);
    do_hit(0);
    wait_mole(3'd7);
    check("seg7_maps_0", mole_seg, 0);
    do_hit(m_window - 1);
    check("gameC_level", level, 1);
    wait_mole(3'd5);
    do_timeout();
    check("gameC_shrunk_window", m_window, 15);
    check("gameC_game_over", game_over, 1);
    done_idle();

    // Randomized games against the model.
    for (int g = 0; g < 4; g++) begin
      start_game();
      for (int m = 0; m < MOLES; m++) begin
        wait_mole(3'($urandom));
        act = $urandom_range(0, 2);
        if (act == 0) do_hit($urandom_range(0, m_window - 1));
        else if (act == 1) do_wrong($urandom_range(0, m_window - 1));
        else do_timeout();
      end
      done_idle();
    end

    // New game pressed mid-mole with two hits on the board.
    start_game();
    wait_mole(3'd1);
    do_hit($urandom_range(0, m_window - 1));
    wait_mole(3'd4);
    do_hit($urandom_range(0, m_window - 1));
    check("abort_pre_hits", hits, 2);
    wait_mole(3'd6);
    show_steps(2);
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    check("abort_pulses", {hit_pulse, miss_pulse}, 0);
    check("abort_hits", hits, 0);
    check("abort_level", level, 0);
    check("abort_valid", mole_valid, 0);
    model_new();
    wait_mole(3'd5);
    do_timeout();
    check("abort_window_reset", m_window, 20);

    // Asynchronous reset in the middle of a mole.
    wait_mole(3'd5);
    show_steps(3);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (mole_valid !== 1'b0 || game_over !== 1'b0 || hits !== 8'd0) bad++;
    end
    check("post_reset_idle", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
